// File: rtl/rx_iq_buf_pkg.sv
// Shared constants and helpers for the receiver I/Q sample buffer.
// RXO_BITS mirrors the decimator output width published in kiwi.gen.vh.
package rx_iq_buf_pkg;

  localparam int RXO_BITS = 24;
  localparam int DOUT_W   = 16;
  localparam int MSB_W    = 8;

  typedef enum logic [1:0] {
    SEL_PACKED = 2'd0,
    SEL_I      = 2'd1,
    SEL_Q      = 2'd2
  } dout_sel_e;

  // getI wins over getQ; with neither set the top bytes of both are packed.
  function automatic dout_sel_e dout_sel(input logic get_i, input logic get_q);
    dout_sel_e sel;
    sel = SEL_PACKED;
    if (get_i) begin
      sel = SEL_I;
    end else if (get_q) begin
      sel = SEL_Q;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rx_iq_ram.sv
// Simple dual-port sample storage: one write port, one registered read port.
// The read register doubles as the buffer's head register, so it has a
// synchronous clear and only updates when a read is requested.
module rx_iq_ram #(
  parameter int DW = 48,
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, held between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_iq_buf.sv
// Receiver I/Q pair buffer: queues decimated sample pairs from the receiver
// and presents the oldest pair (the head) to a 16-bit readout port.
// Flow control, head prefetch and sticky error flags live here; storage is
// in rx_iq_ram.
module rx_iq_buf
  import rx_iq_buf_pkg::*;
#(
  parameter int WIDTH      = RXO_BITS,
  parameter int DEPTH_LOG2 = 9,
  parameter int BLOCK      = 170
) (
  input  logic                    adc_clk,
  input  logic                    reset,
  input  logic                    in_strobe,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic signed [WIDTH-1:0] in_q,
  input  logic                    rd_getI,
  input  logic                    rd_getQ,
  input  logic                    rd_next,
  input  logic                    clr_flags,
  output logic [DOUT_W-1:0]       dout,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    ready,
  output logic                    head_valid,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [31:0]         BLOCK_U  = 32'(BLOCK);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  head_valid_q, head_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full;
  logic                  empty;
  logic                  pop_ok;
  logic                  wr_ok;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [2*WIDTH-1:0]    head_pair;
  logic [WIDTH-1:0]      head_i;
  logic [WIDTH-1:0]      head_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a write into a full buffer is
  // accepted when it coincides with an accepted pop.
  assign pop_ok = rd_next & ~empty;
  assign wr_ok  = in_strobe & (~full | pop_ok);

  // Prefetch whenever the head slot is empty, or fetch the successor on a pop.
  // On a pop the address is the next slot; the head stays invalid for one
  // cycle and the successor is re-read from the advanced pointer.
  assign rd_en   = (~head_valid_q & ~empty) | (pop_ok & (count_q > CNT_ONE));
  assign rd_addr = pop_ok ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  rx_iq_ram #(
    .DW (2 * WIDTH),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (adc_clk),
    .rst_i   (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_i, in_q}),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (head_pair)
  );

  assign head_i = head_pair[2*WIDTH-1:WIDTH];
  assign head_q = head_pair[WIDTH-1:0];

  // Next-state for pointers, occupancy, head status and sticky flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (wr_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !wr_ok) begin
      count_d = count_q - CNT_ONE;
    end

    if (pop_ok) begin
      head_valid_d = 1'b0;
    end else if (rd_en) begin
      head_valid_d = 1'b1;
    end

    if (clr_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (in_strobe && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (rd_next && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Readout word selection from the head pair.
  always_comb begin
    dout = '0;
    case (dout_sel(rd_getI, rd_getQ))
      SEL_I:   dout = head_i[DOUT_W-1:0];
      SEL_Q:   dout = head_q[DOUT_W-1:0];
      default: dout = {head_i[WIDTH-1 -: MSB_W], head_q[WIDTH-1 -: MSB_W]};
    endcase
  end

  assign count      = count_q;
  assign ready      = ~reset & (32'(count_q) >= BLOCK_U);
  assign head_valid = head_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_rx_iq_buf.sv
// Bench for rx_iq_buf: a default-depth instance (A) and a 16-deep instance (B)
// run against queue-based reference models updated on every clock edge.
module tb_rx_iq_buf;

  localparam int W   = 24;
  localparam int DA  = 9;
  localparam int DB  = 4;
  localparam int BLK = 170;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic rst_a, stb_a, gi_a, gq_a, nx_a, clr_a;
  logic signed [W-1:0] i_a, q_a;
  logic [15:0] dout_a;
  logic [DA:0] cnt_a;
  logic rdy_a, hv_a, ovf_a, udf_a;

  logic rst_b, stb_b, gi_b, gq_b, nx_b, clr_b;
  logic signed [W-1:0] i_b, q_b;
  logic [15:0] dout_b;
  logic [DB:0] cnt_b;
  logic rdy_b, hv_b, ovf_b, udf_b;

  rx_iq_buf #(.WIDTH(W), .DEPTH_LOG2(DA), .BLOCK(BLK)) dut_a (
    .adc_clk(clk), .reset(rst_a), .in_strobe(stb_a), .in_i(i_a), .in_q(q_a),
    .rd_getI(gi_a), .rd_getQ(gq_a), .rd_next(nx_a), .clr_flags(clr_a),
    .dout(dout_a), .count(cnt_a), .ready(rdy_a), .head_valid(hv_a),
    .overflow(ovf_a), .underflow(udf_a));

  rx_iq_buf #(.WIDTH(W), .DEPTH_LOG2(DB), .BLOCK(BLK)) dut_b (
    .adc_clk(clk), .reset(rst_b), .in_strobe(stb_b), .in_i(i_b), .in_q(q_b),
    .rd_getI(gi_b), .rd_getQ(gq_b), .rd_next(nx_b), .clr_flags(clr_b),
    .dout(dout_b), .count(cnt_b), .ready(rdy_b), .head_valid(hv_b),
    .overflow(ovf_b), .underflow(udf_b));

  // Reference state: queued pairs {I,Q} (front = head) and sticky flags.
  logic [47:0] mq_a[$];
  logic [47:0] mq_b[$];
  bit movf_a, mudf_a, movf_b, mudf_b;

  function automatic logic [15:0] exp_dout(logic [47:0] p, logic gi, logic gq);
    logic [23:0] iv;
    logic [23:0] qv;
    iv = p[47:24];
    qv = p[23:0];
    if (gi) return iv[15:0];
    if (gq) return qv[15:0];
    return {iv[23:16], qv[23:16]};
  endfunction

  // One clock edge: update both models from the inputs present at the edge.
  task automatic tick();
    bit pop_ok, wr_ok;
    @(posedge clk);
    if (rst_a) begin
      mq_a.delete(); movf_a = 0; mudf_a = 0;
    end else begin
      pop_ok = nx_a && (mq_a.size() > 0);
      wr_ok  = stb_a && ((mq_a.size() < (1 << DA)) || pop_ok);
      if (clr_a) begin movf_a = 0; mudf_a = 0; end
      else begin
        if (stb_a && !wr_ok) movf_a = 1;
        if (nx_a && !pop_ok) mudf_a = 1;
      end
      if (pop_ok) void'(mq_a.pop_front());
      if (wr_ok) mq_a.push_back({i_a, q_a});
    end
    if (rst_b) begin
      mq_b.delete(); movf_b = 0; mudf_b = 0;
    end else begin
      pop_ok = nx_b && (mq_b.size() > 0);
      wr_ok  = stb_b && ((mq_b.size() < (1 << DB)) || pop_ok);
      if (clr_b) begin movf_b = 0; mudf_b = 0; end
      else begin
        if (stb_b && !wr_ok) movf_b = 1;
        if (nx_b && !pop_ok) mudf_b = 1;
      end
      if (pop_ok) void'(mq_b.pop_front());
      if (wr_ok) mq_b.push_back({i_b, q_b});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; stb_a = 1; nx_b = 1; i_a = 24'h111111; q_a = 24'h222222;
    tick(); tick();
    stb_a = 0; nx_b = 0;
    checks++; if (cnt_a !== '0) begin errors++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
    checks++; if (hv_a !== 1'b0) begin errors++; $display("FAIL reset_hv_a got=%b exp=0", hv_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rdy_a got=%b exp=0", rdy_a); end
    checks++; if ({ovf_a, udf_a, ovf_b, udf_b} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ovf_a, udf_a, ovf_b, udf_b}); end
    checks++; if (dout_a !== 16'h0000) begin errors++; $display("FAIL reset_dout_a got=%h exp=0000", dout_a); end
    checks++; if (dout_b !== 16'h0000) begin errors++; $display("FAIL reset_dout_b got=%h exp=0000", dout_b); end
    checks++; if (cnt_b !== '0 || hv_b !== 1'b0) begin errors++; $display("FAIL reset_b got cnt=%0d hv=%b exp 0/0", cnt_b, hv_b); end
    rst_a = 0; rst_b = 0;
  endtask

  task automatic test_single_pair();
    stb_a = 1; i_a = 24'h123456; q_a = 24'hABCDEF;
    tick();
    stb_a = 0;
    checks++; if (cnt_a !== 10'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", cnt_a); end
    checks++; if (hv_a !== 1'b0) begin errors++; $display("FAIL single_hv_early got=%b exp=0", hv_a); end
    tick();
    checks++; if (hv_a !== 1'b1) begin errors++; $display("FAIL single_hv got=%b exp=1", hv_a); end
    gi_a = 1; #1;
    checks++; if (dout_a !== 16'h3456) begin errors++; $display("FAIL single_getI got=%h exp=3456", dout_a); end
    gq_a = 1; #1;
    checks++; if (dout_a !== exp_dout(mq_a[0], 1'b1, 1'b1)) begin errors++; $display("FAIL single_prio got=%h exp=%h", dout_a, exp_dout(mq_a[0], 1'b1, 1'b1)); end
    gi_a = 0; #1;
    checks++; if (dout_a !== 16'hCDEF) begin errors++; $display("FAIL single_getQ got=%h exp=CDEF", dout_a); end
    gq_a = 0; #1;
    checks++; if (dout_a !== 16'h12AB) begin errors++; $display("FAIL single_packed got=%h exp=12AB", dout_a); end
    nx_a = 1;
    tick();
    nx_a = 0;
    checks++; if (int'(cnt_a) !== mq_a.size() || hv_a !== 1'b0) begin errors++; $display("FAIL single_pop got cnt=%0d hv=%b exp cnt=%0d hv=0", cnt_a, hv_a, mq_a.size()); end
  endtask

  task automatic test_fill_block();
    rst_a = 1; tick(); rst_a = 0;
    for (int n = 1; n <= BLK; n++) begin
      stb_a = 1; i_a = W'($urandom); q_a = W'($urandom);
      tick();
      checks++; if (rdy_a !== (mq_a.size() >= BLK)) begin errors++; $display("FAIL fill_ready n=%0d got=%b exp=%b", n, rdy_a, mq_a.size() >= BLK); end
      checks++; if (int'(cnt_a) !== mq_a.size()) begin errors++; $display("FAIL fill_cnt n=%0d got=%0d exp=%0d", n, cnt_a, mq_a.size()); end
    end
    stb_a = 0;
    for (int k = 0; k < 4 && hv_a !== 1'b1; k++) tick();
    checks++; if (hv_a !== 1'b1) begin errors++; $display("FAIL fill_hv_timeout got=%b exp=1", hv_a); end
    checks++; if (dout_a !== exp_dout(mq_a[0], 1'b0, 1'b0)) begin errors++; $display("FAIL fill_head got=%h exp=%h", dout_a, exp_dout(mq_a[0], 1'b0, 1'b0)); end
    nx_a = 1; tick(); nx_a = 0;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL fill_ready_fall got=%b exp=0", rdy_a); end
    checks++; if (cnt_a !== 10'd169) begin errors++; $display("FAIL fill_cnt_pop got=%0d exp=169", cnt_a); end
    stb_a = 1; i_a = W'($urandom); q_a = W'($urandom); tick(); stb_a = 0;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL fill_ready_again got=%b exp=1", rdy_a); end
    rst_a = 1; #1;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL ready_in_reset got=%b exp=0", rdy_a); end
    tick(); rst_a = 0;
    checks++; if (cnt_a !== '0 || hv_a !== 1'b0) begin errors++; $display("FAIL fill_reset got cnt=%0d hv=%b exp 0/0", cnt_a, hv_a); end
  endtask

  task automatic test_underflow();
    nx_a = 1; tick(); nx_a = 0;
    checks++; if (udf_a !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", udf_a); end
    checks++; if (cnt_a !== '0 || hv_a !== 1'b0) begin errors++; $display("FAIL udf_state got cnt=%0d hv=%b exp 0/0", cnt_a, hv_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL udf_ovf got=%b exp=0", ovf_a); end
    nx_a = 1; clr_a = 1; tick(); nx_a = 0; clr_a = 0;
    checks++; if (udf_a !== mudf_a) begin errors++; $display("FAIL udf_clr_prio got=%b exp=%b", udf_a, mudf_a); end
    nx_a = 1; tick(); nx_a = 0; clr_a = 1; tick(); clr_a = 0;
    checks++; if (udf_a !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", udf_a); end
  endtask

  task automatic test_overflow();
    int drained;
    rst_b = 1; tick(); rst_b = 0;
    for (int n = 0; n < 17; n++) begin
      stb_b = 1; i_b = W'($urandom); q_b = W'($urandom);
      tick();
      checks++; if (int'(cnt_b) !== mq_b.size() || ovf_b !== movf_b) begin errors++; $display("FAIL ovf_fill n=%0d got cnt=%0d ovf=%b exp cnt=%0d ovf=%b", n, cnt_b, ovf_b, mq_b.size(), movf_b); end
    end
    stb_b = 0;
    checks++; if (cnt_b !== 5'd16 || ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_full got cnt=%0d ovf=%b exp 16/1", cnt_b, ovf_b); end
    drained = 0;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4 && hv_b !== 1'b1; k++) tick();
      if (hv_b !== 1'b1) begin
        errors++; $display("FAIL ovf_drain_timeout at pair %0d hv=%b exp=1", n, hv_b);
        break;
      end
      gi_b = 1'($urandom); gq_b = 1'($urandom); #1;
      checks++; if (dout_b !== exp_dout(mq_b[0], gi_b, gq_b)) begin errors++; $display("FAIL ovf_drain_data pair=%0d got=%h exp=%h", n, dout_b, exp_dout(mq_b[0], gi_b, gq_b)); end
      nx_b = 1; tick(); nx_b = 0; gi_b = 0; gq_b = 0;
      drained++;
    end
    checks++; if (drained !== 16 || cnt_b !== '0) begin errors++; $display("FAIL ovf_drained got n=%0d cnt=%0d exp 16/0", drained, cnt_b); end
    tick(); tick(); tick();
    checks++; if (hv_b !== 1'b0) begin errors++; $display("FAIL ovf_extra_pair got hv=%b exp=0", hv_b); end
    clr_b = 1; tick(); clr_b = 0;
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_b); end
  endtask

  task automatic test_wrap_simul();
    int pushed, popped, sz;
    bit do_pop, do_stb;
    rst_b = 1; tick(); rst_b = 0;
    pushed = 0; popped = 0;
    for (int n = 0; n < 16; n++) begin
      stb_b = 1; i_b = W'($urandom); q_b = W'($urandom); pushed++;
      tick();
    end
    stb_b = 0;
    for (int k = 0; k < 4 && hv_b !== 1'b1; k++) tick();
    for (int cyc = 0; cyc < 800 && popped < 40; cyc++) begin
      sz = mq_b.size();
      do_pop = (hv_b === 1'b1) && ((sz == 16) || ($urandom_range(0, 1) == 1));
      do_stb = (pushed < 40) && ((sz < 16) || do_pop) && ((sz == 16) || ($urandom_range(0, 2) != 0));
      if (do_stb) begin
        stb_b = 1; i_b = W'($urandom); q_b = W'($urandom); pushed++;
      end
      if (do_pop) begin
        gi_b = 1'($urandom); gq_b = 1'($urandom); nx_b = 1; #1;
        checks++; if (dout_b !== exp_dout(mq_b[0], gi_b, gq_b)) begin errors++; $display("FAIL wrap_order pop=%0d got=%h exp=%h", popped, dout_b, exp_dout(mq_b[0], gi_b, gq_b)); end
        popped++;
      end
      tick();
      stb_b = 0; nx_b = 0; gi_b = 0; gq_b = 0;
      if (do_pop && do_stb && sz == 16) begin
        checks++; if (cnt_b !== 5'd16) begin errors++; $display("FAIL wrap_simul_cnt got=%0d exp=16", cnt_b); end
      end
      checks++; if (int'(cnt_b) !== mq_b.size()) begin errors++; $display("FAIL wrap_cnt cyc=%0d got=%0d exp=%0d", cyc, cnt_b, mq_b.size()); end
    end
    checks++; if (popped !== 40) begin errors++; $display("FAIL wrap_timeout popped=%0d exp=40", popped); end
    checks++; if (ovf_b !== 1'b0 || cnt_b !== '0) begin errors++; $display("FAIL wrap_end got ovf=%b cnt=%0d exp 0/0", ovf_b, cnt_b); end
  endtask

  task automatic test_reset_mid();
    logic [47:0] p;
    rst_b = 1; tick(); rst_b = 0;
    for (int n = 0; n < 5; n++) begin
      stb_b = 1; i_b = W'($urandom); q_b = W'($urandom); tick();
    end
    stb_b = 0;
    checks++; if (cnt_b !== 5'd5) begin errors++; $display("FAIL mid_pre_cnt got=%0d exp=5", cnt_b); end
    rst_b = 1; stb_b = 1; nx_b = 1; tick(); rst_b = 0; stb_b = 0; nx_b = 0;
    checks++; if (cnt_b !== '0 || hv_b !== 1'b0 || rdy_b !== 1'b0) begin errors++; $display("FAIL mid_reset got cnt=%0d hv=%b rdy=%b exp 0/0/0", cnt_b, hv_b, rdy_b); end
    checks++; if (ovf_b !== 1'b0 || udf_b !== 1'b0) begin errors++; $display("FAIL mid_flags got ovf=%b udf=%b exp 0/0", ovf_b, udf_b); end
    p = {24'hC0FFEE, 24'h5A5A5A};
    stb_b = 1; i_b = p[47:24]; q_b = p[23:0]; tick(); stb_b = 0;
    checks++; if (hv_b !== 1'b0 || cnt_b !== 5'd1) begin errors++; $display("FAIL mid_first got hv=%b cnt=%0d exp 0/1", hv_b, cnt_b); end
    tick();
    checks++; if (hv_b !== 1'b1) begin errors++; $display("FAIL mid_hv got=%b exp=1", hv_b); end
    checks++; if (dout_b !== exp_dout(p, 1'b0, 1'b0)) begin errors++; $display("FAIL mid_head got=%h exp=%h", dout_b, exp_dout(p, 1'b0, 1'b0)); end
  endtask

  initial begin
    rst_a = 1; stb_a = 0; gi_a = 0; gq_a = 0; nx_a = 0; clr_a = 0; i_a = '0; q_a = '0;
    rst_b = 1; stb_b = 0; gi_b = 0; gq_b = 0; nx_b = 0; clr_b = 0; i_b = '0; q_b = '0;
    test_reset();
    test_single_pair();
    test_fill_block();
    test_underflow();
    test_overflow();
    test_wrap_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_iq_buf.md
RX_IQ_BUF -- requirements
Module: rx_iq_buf

Interface
REQ-001 SHALL have parameter WIDTH, default RXO_BITS (24); bit width of each decimated I and Q sample.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9; the buffer holds 2**DEPTH_LOG2 I/Q pairs.
REQ-003 SHALL have parameter BLOCK, default 170; number of buffered pairs at which ready asserts.
REQ-004 SHALL have port adc_clk, input, 1 bit; the only clock. All logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-006 SHALL have port in_strobe, input, 1 bit; one-cycle pulse marking a valid I/Q pair (the receiver's rx_avail_A).
REQ-007 SHALL have ports in_i and in_q, input, WIDTH bits each, signed; the sample pair, valid when in_strobe is high.
REQ-008 SHALL have ports rd_getI and rd_getQ, input, 1 bit each; select the word presented on dout.
REQ-009 SHALL have port rd_next, input, 1 bit; a one-cycle pulse that pops the head pair.
REQ-010 SHALL have port dout, output, 16 bits; head-pair word, combinational from the head register and selects.
REQ-011 SHALL have port count, output, DEPTH_LOG2+1 bits; number of pairs stored, including the head.
REQ-012 SHALL have port ready, output, 1 bit; asserted while count >= BLOCK.
REQ-013 SHALL have ports head_valid, overflow and underflow, output, 1 bit each.
REQ-014 SHALL have port clr_flags, input, 1 bit; clears overflow and underflow.

Function
REQ-015 SHALL select dout as follows:
- rd_getI: head_i[15:0].
- else rd_getQ: head_q[15:0].
- else: {head_i[WIDTH-1 -:8], head_q[WIDTH-1 -:8]}.
REQ-016 SHALL write {in_i,in_q} at the write pointer on every in_strobe when not full (count < 2**DEPTH_LOG2), then increment the write pointer modulo depth.
REQ-017 SHALL, on in_strobe while full, drop the pair, leave the pointers unchanged, and set overflow (sticky).
REQ-018 SHALL, if rd_next and in_strobe occur in the same cycle while full, apply the pop first and accept the write; count stays unchanged.
REQ-019 SHALL, on rd_next while count == 0, ignore the pop, set underflow (sticky), and leave count unchanged.
REQ-020 SHALL keep count = writes accepted − pops accepted; simultaneous accepted write and pop leave count unchanged.
REQ-021 SHALL read RAM synchronously (1 cycle); head register loads from the read pointer whenever head_valid is low and count > 0, or when a pop is accepted and count > 1.
REQ-022 SHALL assert head_valid exactly 2 cycles after the first in_strobe into an empty buffer (write cycle + RAM read); dout then shows that pair.
REQ-023 SHALL, after an accepted pop with count > 1, present the next pair with head_valid high 2 cycles later; head_valid is low in between.
REQ-024 SHALL wrap both pointers from 2**DEPTH_LOG2−1 to 0 with no gap or duplicate.
REQ-025 SHALL give clr_flags priority over a set of the same flag in the same cycle.

Reset
REQ-026 SHALL, when reset is high at a clock edge, clear the pointers, count, head_valid, overflow and underflow to 0 regardless of other inputs; RAM contents are not cleared.
REQ-027 SHALL hold ready low and dout at 16'h0000 while reset is applied, with the head register cleared.
REQ-028 SHALL treat reset mid-operation as discarding all pending pairs; the first in_strobe after reset is accepted normally.

Structure
REQ-029 SHALL take RXO_BITS from the shared generated include kiwi.gen.vh; no new package types are required.
REQ-030 SHALL place storage in one sub-module, rx_iq_ram: simple dual-port, 2*WIDTH wide, 2**DEPTH_LOG2 deep, registered read, inferable as block RAM.
REQ-031 SHALL keep flow control (pointers, count, head prefetch, flags) in rx_iq_buf itself.

Verification
REQ-032 SHALL cover single pair: reset, then in_strobe with in_i=24'h123456, in_q=24'hABCDEF → 2 cycles later head_valid=1, count=1; dout=16'h3456 (getI), 16'hCDEF (getQ), 16'h12AB (neither).
REQ-033 SHALL cover fill to BLOCK: 170 strobes → ready rises the cycle after the 170th write; one rd_next → ready falls, count=169.
REQ-034 SHALL cover overflow (DEPTH_LOG2=4): 17 strobes → count=16, overflow=1, 17th pair absent when draining; clr_flags → overflow=0.
REQ-035 SHALL cover underflow: rd_next on empty buffer → underflow=1, count=0, head_valid=0.
REQ-036 SHALL cover wrap plus simultaneity (DEPTH_LOG2=4): 40 pairs with interleaved pops and same-cycle write+pop when full → read order equals write order, no drops, overflow=0.
REQ-037 SHALL cover reset mid-operation: reset with count=5 → next cycle count=0, head_valid=0, ready=0; a new strobe appears as head 2 cycles after it.
